// File: rtl/usb_kbd_led_pkg.sv
// usb_kbd_led_pkg: keycodes, device types, LED bit positions and controller states for the lock-LED controller
package usb_kbd_led_pkg;

    localparam logic [7:0] KC_NUMLOCK      = 8'h53;
    localparam logic [7:0] KC_CAPSLOCK     = 8'h39;
    localparam logic [7:0] KC_SCROLLLOCK   = 8'h47;
    localparam logic [7:0] KC_ERR_ROLLOVER = 8'h01;

    localparam logic [1:0] TYP_NONE     = 2'd0;
    localparam logic [1:0] TYP_KEYBOARD = 2'd1;
    localparam logic [1:0] TYP_MOUSE    = 2'd2;
    localparam logic [1:0] TYP_GAMEPAD  = 2'd3;

    localparam int LED_NUM     = 0;
    localparam int LED_CAPS    = 1;
    localparam int LED_SCROLL  = 2;
    localparam int LED_COMPOSE = 3;

    // wide enough for HOLDOFF_CYCLES-1 at the largest legal holdoff of 2^20
    localparam int CNT_W = 20;

    typedef enum logic [1:0] {IDLE, SEND, HOLD} led_state_e;

endpackage

// File: rtl/usb_kbd_led_ctrl_lock_edge.sv
// kbd_lock_edge: detects a fresh press of one lock key across successive keyboard reports
module kbd_lock_edge #(
    parameter logic [7:0] KEYCODE = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       proc,
    input  logic [7:0] key1,
    input  logic [7:0] key2,
    input  logic [7:0] key3,
    input  logic [7:0] key4,
    output logic       press
);

    logic prev;
    logic present;

    assign present = (key1 == KEYCODE) || (key2 == KEYCODE) || (key3 == KEYCODE) || (key4 == KEYCODE);
    assign press   = proc && present && !prev;

    // remember whether the key was held in the last processed report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prev <= 1'b0;
        else if (clr)
            prev <= 1'b0;
        else if (proc)
            prev <= present;
    end

endmodule

// File: rtl/usb_kbd_led_ctrl.sv
// usb_kbd_led_ctrl: tracks keyboard lock keys and drives rate-limited LED updates to the USB HID host.
// Build option: USB_KBD_LED_NUMLOCK_DEFAULT_EN turns Num Lock on at every attach.
module usb_kbd_led_ctrl
    import usb_kbd_led_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 12000
) (
    input  logic       usbclk,
    input  logic       usbrst_n,
    input  logic [1:0] typ,
    input  logic       report,
    input  logic       conerr,
    input  logic [7:0] key1,
    input  logic [7:0] key2,
    input  logic [7:0] key3,
    input  logic [7:0] key4,
    output logic       update_leds_stb,
    output logic [3:0] leds,
    output logic [2:0] lock_state
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
`ifdef USB_KBD_LED_NUMLOCK_DEFAULT_EN
    localparam logic [2:0] ATTACH_LOCK = 3'b001;
`else
    localparam logic [2:0] ATTACH_LOCK = 3'b000;
`endif

    led_state_e       state, state_next;
    logic             attached;
    logic             att_now;
    logic             attach_rise;
    logic             detach;
    logic             proc;
    logic             pending;
    logic [2:0]       press;
    logic [CNT_W-1:0] cnt;

    assign att_now     = (typ == TYP_KEYBOARD) && !conerr;
    assign attach_rise = att_now && !attached;
    assign detach      = conerr || (attached && !att_now);
    assign proc        = report && attached && (typ == TYP_KEYBOARD) && !detach && (key1 != KC_ERR_ROLLOVER);

    kbd_lock_edge #(.KEYCODE(KC_NUMLOCK)) u_num (
        .clk(usbclk), .rst_n(usbrst_n), .clr(detach), .proc(proc),
        .key1(key1), .key2(key2), .key3(key3), .key4(key4), .press(press[LED_NUM])
    );

    kbd_lock_edge #(.KEYCODE(KC_CAPSLOCK)) u_caps (
        .clk(usbclk), .rst_n(usbrst_n), .clr(detach), .proc(proc),
        .key1(key1), .key2(key2), .key3(key3), .key4(key4), .press(press[LED_CAPS])
    );

    kbd_lock_edge #(.KEYCODE(KC_SCROLLLOCK)) u_scroll (
        .clk(usbclk), .rst_n(usbrst_n), .clr(detach), .proc(proc),
        .key1(key1), .key2(key2), .key3(key3), .key4(key4), .press(press[LED_SCROLL])
    );

    // next state and strobe; a detach drops back to IDLE and suppresses any strobe
    always_comb begin
        state_next      = state;
        update_leds_stb = 1'b0;
        if (detach)
            state_next = IDLE;
        else begin
            case (state)
                IDLE: if (pending) state_next = SEND;
                SEND: begin
                    update_leds_stb = 1'b1;
                    state_next      = HOLD;
                end
                HOLD: if (cnt == '0) state_next = pending ? SEND : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // state and attach tracking
    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            state    <= IDLE;
            attached <= 1'b0;
        end else begin
            state    <= state_next;
            attached <= att_now;
        end
    end

    // lock bits and the coalesced update request; a new press outranks the clear in SEND
    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            lock_state <= 3'b000;
            pending    <= 1'b0;
        end else if (detach) begin
            lock_state <= 3'b000;
            pending    <= 1'b0;
        end else begin
            lock_state <= attach_rise ? ATTACH_LOCK : lock_state ^ press;
            pending    <= (attach_rise || (|press)) ? 1'b1 : (state == SEND) ? 1'b0 : pending;
        end
    end

    // LED snapshot taken on entry to SEND, and the holdoff countdown
    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            leds <= 4'h0;
            cnt  <= '0;
        end else if (detach) begin
            leds <= 4'h0;
            cnt  <= '0;
        end else begin
            leds <= (state_next == SEND) ? {1'b0, lock_state} : leds;
            cnt  <= (state == SEND) ? HOLD_LOAD : (state == HOLD && cnt != '0) ? cnt - CNT_W'(1) : cnt;
        end
    end

endmodule

// File: tb/tb_usb_kbd_led_ctrl.sv
// tb_usb_kbd_led_ctrl: scoreboard bench with a timestamp-based reference model of the lock-LED controller
module tb_usb_kbd_led_ctrl;

    localparam int H = 16;
`ifdef USB_KBD_LED_NUMLOCK_DEFAULT_EN
    localparam logic [2:0] ATT_LOCK = 3'b001;
`else
    localparam logic [2:0] ATT_LOCK = 3'b000;
`endif
    localparam int NEVER = -1000000;

    logic       usbclk = 1'b0;
    logic       usbrst_n = 1'b0;
    logic [1:0] typ = 2'd0;
    logic       report = 1'b0;
    logic       conerr = 1'b0;
    logic [7:0] key1 = 8'h00, key2 = 8'h00, key3 = 8'h00, key4 = 8'h00;
    logic       update_leds_stb;
    logic [3:0] leds;
    logic [2:0] lock_state;

    always #5 usbclk = ~usbclk;

    usb_kbd_led_ctrl #(.HOLDOFF_CYCLES(H)) dut (
        .usbclk(usbclk), .usbrst_n(usbrst_n), .typ(typ), .report(report), .conerr(conerr),
        .key1(key1), .key2(key2), .key3(key3), .key4(key4),
        .update_leds_stb(update_leds_stb), .leds(leds), .lock_state(lock_state)
    );

    typedef struct {
        int         cyc;
        logic [3:0] leds;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // model: values held during the current cycle (m_) and for the next one (n_)
    logic       m_att = 0, m_pend = 0, m_send = 0, n_att = 0, n_pend = 0, n_send = 0;
    logic [2:0] m_lock = 0, m_prev = 0, n_lock = 0, n_prev = 0;
    logic [3:0] m_leds = 0, n_leds = 0;
    int         m_last = NEVER, n_last = NEVER;
    logic [7:0] codes [3] = '{8'h53, 8'h39, 8'h47};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        {m_att, m_pend, m_send, n_att, n_pend, n_send} = '0;
        {m_lock, m_prev, n_lock, n_prev} = '0;
        {m_leds, n_leds} = '0;
        m_last = NEVER;
        n_last = NEVER;
    endtask

    // next-cycle state from the current inputs; a send is allowed once H cycles have passed since the last one
    task automatic model_next();
        logic       att_now, det, rise, proc;
        logic [2:0] pres, newp;
        if (!usbrst_n) begin
            {n_att, n_pend, n_send, n_lock, n_prev, n_leds} = '0;
            n_last = NEVER;
            return;
        end
        att_now = (typ == 2'd1) && !conerr;
        det     = conerr || (m_att && !att_now);
        rise    = att_now && !m_att;
        if (m_send && !det) exp_q.push_back('{cyc, m_leds});
        proc = report && m_att && (typ == 2'd1) && !conerr && (key1 != 8'h01);
        for (int i = 0; i < 3; i++) begin
            pres[i] = (key1 == codes[i]) || (key2 == codes[i]) || (key3 == codes[i]) || (key4 == codes[i]);
            newp[i] = proc && pres[i] && !m_prev[i];
        end
        n_att = att_now;
        if (det) begin
            {n_pend, n_send, n_lock, n_prev, n_leds} = '0;
            n_last = NEVER;
        end else begin
            n_prev = proc ? pres : m_prev;
            n_lock = rise ? ATT_LOCK : m_lock ^ newp;
            n_send = m_pend && !m_send && (cyc >= m_last + H);
            n_pend = (rise || (|newp)) ? 1'b1 : m_send ? 1'b0 : m_pend;
            n_leds = n_send ? {1'b0, m_lock} : m_leds;
            n_last = m_send ? cyc : m_last;
        end
    endtask

    task automatic cyc_in(input logic [1:0] t, input logic r, input logic ce,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        @(posedge usbclk);
        #1;
        m_att = n_att; m_pend = n_pend; m_send = n_send;
        m_lock = n_lock; m_prev = n_prev; m_leds = n_leds; m_last = n_last;
        cyc++;
        typ = t; report = r; conerr = ce;
        key1 = a; key2 = b; key3 = c; key4 = d;
        model_next();
    endtask

    task automatic nop(input int n, input logic [1:0] t);
        for (int i = 0; i < n; i++) cyc_in(t, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic rep(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        cyc_in(2'd1, 1'b1, 1'b0, a, b, c, d);
    endtask

    task automatic release_rst();
        usbrst_n = 1'b1;
        model_next();
    endtask

    function automatic logic [7:0] rkey();
        case ($urandom_range(0, 7))
            0, 1:    return 8'h00;
            2:       return 8'h53;
            3:       return 8'h39;
            4:       return 8'h47;
            5:       return 8'h04;
            default: return 8'($urandom);
        endcase
    endfunction

    // monitor: compare live outputs with the model and pop the scoreboard on every strobe
    always @(negedge usbclk) begin
        check("lock_state", int'(lock_state), int'(m_lock));
        check("leds", int'(leds), int'(m_leds));
        if (update_leds_stb) begin
            if (exp_q.size() == 0)
                check("unexpected_stb", int'(update_leds_stb), 0);
            else begin
                e = exp_q.pop_front();
                check("stb_cycle", cyc, e.cyc);
                check("stb_leds", int'(leds), int'(e.leds));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            void'(exp_q.pop_front());
            check("missing_stb", int'(update_leds_stb), 1);
        end
    end

    initial begin
        logic [1:0] rt;
        nop(3, 2'd0);
        release_rst();
        nop(100, 2'd0);
        nop(30, 2'd1);
        rep(8'h39, 8'h00, 8'h00, 8'h00);
        nop(25, 2'd1);
        rep(8'h39, 8'h00, 8'h00, 8'h00);
        nop(25, 2'd1);
        rep(8'h00, 8'h00, 8'h00, 8'h00);
        nop(3, 2'd1);
        rep(8'h00, 8'h00, 8'h39, 8'h00);
        nop(25, 2'd1);
        rep(8'h39, 8'h00, 8'h00, 8'h00);
        nop(4, 2'd1);
        rep(8'h53, 8'h00, 8'h00, 8'h00);
        nop(40, 2'd1);
        rep(8'h01, 8'h53, 8'h00, 8'h00);
        nop(25, 2'd1);
        rep(8'h53, 8'h00, 8'h00, 8'h00);
        nop(25, 2'd1);
        rep(8'h00, 8'h00, 8'h00, 8'h00);
        rep(8'h39, 8'h53, 8'h47, 8'h39);
        nop(5, 2'd1);
        cyc_in(2'd1, 1'b1, 1'b1, 8'h47, 8'h00, 8'h00, 8'h00);
        nop(30, 2'd1);
        rep(8'h47, 8'h00, 8'h00, 8'h00);
        nop(5, 2'd1);
        #2;
        usbrst_n = 1'b0;
        #1;
        check("rst_stb", int'(update_leds_stb), 0);
        check("rst_leds", int'(leds), 0);
        check("rst_lock", int'(lock_state), 0);
        model_reset();
        exp_q.delete();
        nop(3, 2'd1);
        release_rst();
        nop(30, 2'd1);
        rt = 2'd1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) rt = 2'($urandom);
            if ($urandom_range(0, 7) == 0) rt = 2'd1;
            cyc_in(rt, $urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0,
                   ($urandom_range(0, 19) == 0) ? 8'h01 : rkey(), rkey(), rkey(), rkey());
        end
        nop(40, 2'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
